// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and frame constants for the UART RAM loader
// Contents: loader state enum, default sync marker, frame field byte counts.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int ADDR_FIELD_BYTES = 2;
  localparam int CNT_FIELD_BYTES  = 2;
  localparam int WORD_BYTES       = 4;
  localparam int CSUM_FIELD_BYTES = 1;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs little-endian bytes into 32-bit words
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           drops any partial word and any pending word_ready
//   byte_valid      byte_in is a data byte to pack
//   byte_in         data byte
//   lane            lane the next byte will land in (0..3)
//   word            assembled word (byte k in bits 8k+7:8k)
//   word_ready      one-cycle strobe, the cycle after the 4th byte
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else if (clear) begin
      lane_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= byte_valid && (lane_q == LAST_LANE);
      // A byte arriving while word_ready is high overwrites lane 0 only at
      // the end of that cycle, so the word being written stays intact.
      if (byte_valid) begin
        word_q[{lane_q, 3'b000} +: 8] <= byte_in;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign lane       = lane_q;
  assign word       = word_q;
  assign word_ready = ready_q;

endmodule

// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - loads framed serial data into RAM port 2
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x 4 data bytes, CSUM.
// Optional macro UART_LOADER_CHECKSUM_EN: XOR-checks the CSUM byte.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rx_valid, rx_byte     received byte strobe and value
//   ram_wEn, ram_addr,    RAM port 2 write strobe, word address, data
//   ram_data
//   busy                  frame in progress
//   done                  one-cycle pulse on clean frame completion
//   err                   sticky error, cleared by reset or next SYNC
//   words_written         words written by the current or last frame
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_written
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state, state_next;
  logic [7:0]            addr_hi_q, cnt_hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           words_left_q, ww_q;
  logic [TW-1:0]         tcount_q;
  logic                  err_q, done_q;
  logic [15:0]           addr_full;
  logic [1:0]            lane;
  logic [31:0]           word;
  logic                  word_ready;
  logic                  timeout, sync_hit, csum_accept, csum_ok, asm_clear;

  assign addr_full   = {addr_hi_q, rx_byte};
  // A byte arriving on the expiry cycle resets the count instead of aborting.
  assign timeout     = busy && !rx_valid && (tcount_q == TW'(TIMEOUT_CYCLES - 1));
  assign sync_hit    = (state == IDLE) && rx_valid && (rx_byte == SYNC_BYTE);
  assign csum_accept = (state == CSUM) && rx_valid;
  assign asm_clear   = (state == IDLE) || timeout;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk) begin
    if (reset || sync_hit) begin
      xor_q <= '0;
    end else if (rx_valid && busy && (state != CSUM)) begin
      xor_q <= xor_q ^ rx_byte;
    end
  end

  assign csum_ok = (rx_byte == xor_q);
`else
  assign csum_ok = 1'b1;
`endif

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (rx_valid && (state == DATA)),
    .byte_in    (rx_byte),
    .lane       (lane),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE:    if (rx_byte == SYNC_BYTE) state_next = ADDR_HI;
        ADDR_HI: state_next = ADDR_LO;
        ADDR_LO: state_next = CNT_HI;
        CNT_HI:  state_next = CNT_LO;
        CNT_LO:  state_next = ({cnt_hi_q, rx_byte} == 16'd0) ? CSUM : DATA;
        DATA:    if (lane == 2'd3 && words_left_q == 16'd1) state_next = CSUM;
        CSUM:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    ram_wEn       = word_ready;
    ram_addr      = addr_q;
    ram_data      = word;
    done          = done_q;
    err           = err_q;
    words_written = ww_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hi_q    <= '0;
      cnt_hi_q     <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      ww_q         <= '0;
      tcount_q     <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= csum_accept && csum_ok;

      if (!busy || rx_valid || timeout) tcount_q <= '0;
      else                              tcount_q <= tcount_q + TW'(1);

      if (rx_valid) begin
        unique case (state)
          ADDR_HI: addr_hi_q    <= rx_byte;
          ADDR_LO: addr_q       <= addr_full[ADDR_WIDTH-1:0];
          CNT_HI:  cnt_hi_q     <= rx_byte;
          CNT_LO:  words_left_q <= {cnt_hi_q, rx_byte};
          DATA:    if (lane == 2'd3) words_left_q <= words_left_q - 16'd1;
          default: ;
        endcase
      end

      // Address wraps naturally at 2^ADDR_WIDTH.
      if (word_ready) begin
        addr_q <= addr_q + 1'b1;
        ww_q   <= ww_q + 16'd1;
      end

      if (sync_hit) begin
        err_q <= 1'b0;
        ww_q  <= '0;
      end
      if (timeout || (csum_accept && !csum_ok)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb/tb_uart_ram_loader.sv - self-checking bench for uart_ram_loader
module tb_uart_ram_loader;

  localparam int AW = 12;
  localparam int TO = 100;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic          busy, done, err;
  logic [15:0]   words_written;

  always #5 clk = ~clk;

  uart_ram_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .ram_wEn       (ram_wEn),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [43:0] got_q[$];
  logic [43:0] exp_q[$];

  always @(negedge clk) begin
    if (ram_wEn) got_q.push_back({ram_addr, ram_data});
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      rx_valid = 1'b1;
      rx_byte  = b[i];
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Builds a frame, the list of writes it must produce, and sends it.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] n, input int gap,
                           input bit bad_cs, input logic [31:0] words[$]);
    logic [7:0] b[$];
    logic [7:0] cs;
    int base;
    b = {8'hA5, a[15:8], a[7:0], n[15:8], n[7:0]};
    cs = a[15:8] ^ a[7:0] ^ n[15:8] ^ n[7:0];
    base = int'(a) % (1 << AW);
    exp_q.delete();
    got_q.delete();
    done_cnt = 0;
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] byt;
        byt = 8'((words[i] >> (8 * k)) & 32'hFF);
        b.push_back(byt);
        cs = cs ^ byt;
      end
      exp_q.push_back({AW'((base + i) % (1 << AW)), words[i]});
    end
    b.push_back(bad_cs ? (cs ^ 8'h01) : cs);
    send_bytes(b, gap);
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input string name, input int exp_ww, input bit exp_err, input int exp_done);
    check({name, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), got_q[i][43:32], exp_q[i][43:32]);
      check($sformatf("%s_data%0d", name, i), got_q[i][31:0], exp_q[i][31:0]);
    end
    check({name, "_ww"}, words_written, exp_ww);
    check({name, "_err"}, err, exp_err);
    check({name, "_done"}, done_cnt, exp_done);
    check({name, "_busy"}, busy, 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] cnt;
    int          gap;
    bit          bad_cs;
    int          exp_ww;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] wq[$];
    logic [7:0]  bq[$];

    vecs[0] = '{"wrap",     16'h0FFF, 16'd2, 0,  1'b0, 2, 1'b0, 1};
    vecs[1] = '{"hibits",   16'hF123, 16'd3, 2,  1'b0, 3, 1'b0, 1};
    vecs[2] = '{"zerocnt",  16'h0020, 16'd0, 1,  1'b0, 0, 1'b0, 1};
    vecs[3] = '{"gap99",    16'h0100, 16'd1, 99, 1'b0, 1, 1'b0, 1};
    vecs[4] = '{"badcsum",  16'h0200, 16'd2, 1,  1'b1, 2, CSUM_ON, CSUM_ON ? 0 : 1};
    vecs[5] = '{"b2b",      16'h0555, 16'd4, 0,  1'b0, 4, 1'b0, 1};

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wen", ram_wEn, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ww", words_written, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic load with the literal words.
    wq = {32'h12345678, 32'hDEADBEEF};
    run_frame(16'h0010, 16'd2, 0, 1'b0, wq);
    verify("basic", 2, 1'b0, 1);
    check("basic_lit0", got_q.size() > 0 ? got_q[0] : 44'h0, {12'h010, 32'h12345678});
    check("basic_lit1", got_q.size() > 1 ? got_q[1] : 44'h0, {12'h011, 32'hDEADBEEF});

    // Garbage ahead of a zero-count frame.
    bq = {8'h00, 8'hFF};
    send_bytes(bq, 0);
    wq.delete();
    run_frame(16'h0020, 16'd0, 0, 1'b0, wq);
    verify("garbage", 0, 1'b0, 1);

    foreach (vecs[v]) begin
      wq.delete();
      for (int i = 0; i < int'(vecs[v].cnt); i++) wq.push_back($urandom);
      run_frame(vecs[v].addr, vecs[v].cnt, vecs[v].gap, vecs[v].bad_cs, wq);
      verify(vecs[v].name, vecs[v].exp_ww, vecs[v].exp_err, vecs[v].exp_done);
    end

    // Timeout mid-word: busy must hold for TO-1 idle cycles, then abort.
    got_q.delete();
    done_cnt = 0;
    bq = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
    send_bytes(bq, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_busy_before", busy, 1);
    check("to_err_before", err, 0);
    @(negedge clk);
    check("to_busy", busy, 0);
    check("to_err", err, 1);
    repeat (5) @(negedge clk);
    check("to_nwrites", got_q.size(), 0);
    check("to_done", done_cnt, 0);

    // Reset in the middle of a data word.
    got_q.delete();
    bq = {8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_bytes(bq, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_err", err, 0);
    check("mrst_ww", words_written, 0);
    check("mrst_wen", ram_wEn, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_nwrites", got_q.size(), 0);
    wq = {32'hCAFEF00D};
    run_frame(16'h0030, 16'd1, 0, 1'b0, wq);
    verify("after_rst", 1, 1'b0, 1);

    // Random frames against the frame-level model.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] a;
      int n;
      a = 16'($urandom);
      n = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_frame(a, 16'(n), $urandom_range(0, 3), 1'b0, wq);
      verify($sformatf("rand%0d", r), n, 1'b0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Sits between the simple UART receiver and the RAM's second write port (wEn2/addr2/dataIn2).
- Parses a framed byte stream from the serial link, assembles 32-bit words, and writes them into processor RAM at a host-specified base address.
- Lets a new program or data image be loaded over serial without rebuilding the bitstream.
- Reports busy, done and error status for the MemoryMap and the LEDs.

Parameters:
- ADDR_WIDTH, 12: RAM word-address width.
- TIMEOUT_CYCLES, 1000000: idle clk cycles allowed between bytes mid-frame before abort.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock (same clk as the UART).
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte.
- rx_byte  in  8  received byte.
- ram_wEn  out  1  write strobe to RAM port 2.
- ram_addr  out  ADDR_WIDTH  word address to RAM port 2.
- ram_data  out  32  write data to RAM port 2.
- busy  out  1  high while a frame is in progress (any state except IDLE).
- done  out  1  one-cycle pulse when a frame completes cleanly.
- err  out  1  sticky error flag; cleared by reset or by the next valid SYNC_BYTE.
- words_written  out  16  words written by the current or last frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and word counters 0.
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 data bytes (little-endian per word), then CSUM.
- Address: only the low ADDR_WIDTH bits of {ADDR_HI, ADDR_LO} are used; the upper bits are ignored.
- States: IDLE → ADDR_HI → ADDR_LO → CNT_HI → CNT_LO → DATA → CSUM → IDLE.
- IDLE: non-SYNC bytes are discarded. SYNC_BYTE clears err and words_written, then moves to ADDR_HI.
- CNT_LO: if the assembled count is 0, go directly to CSUM.
- DATA: byte lane index counts 0..3; byte k lands in ram_data[8k+7:8k].
  - On the 4th byte, the next cycle drives ram_wEn=1 for exactly 1 cycle with ram_addr = current address and ram_data = the assembled word.
  - Then the address increments and words_written increments.
- Address wrap: after writing address 2^ADDR_WIDTH−1, the next write goes to address 0. No error is raised.
- CSUM: the byte is consumed and state returns to IDLE. done pulses 1 cycle later (checksum handling: see Optional Feature).
- Timeout: a counter resets on every rx_valid and increments otherwise while busy.
  - On reaching TIMEOUT_CYCLES: err=1, state IDLE, no further writes.
  - A partial word (fewer than 4 bytes) is never written.
  - If rx_valid coincides with the expiry cycle, the byte wins and no timeout occurs.
- rx_valid during the ram_wEn cycle: the byte is accepted normally. The write uses the already-latched word, and the incoming byte goes into lane 0 of the next word.
- Reset mid-frame: the effect is immediate on the next edge, with no write issued.
- Data bytes equal to SYNC_BYTE inside a frame are treated as data, not resync.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR over all bytes after SYNC, up to but excluding CSUM, is compared against the CSUM byte.
  - On mismatch, err=1 and done is not pulsed. Writes already issued stand.
- Disabled:
  - The CSUM byte is consumed and ignored; done always pulses.
  - No XOR register is synthesized.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM);
  - SYNC_BYTE default;
  - frame field byte counts.
- One natural sub-module: loader_word_assembler (byte lane counter plus 32-bit shift/pack register, producing a word_ready strobe).
- The FSM, address counter and timeout counter stay in the top module.

Test Plan:
- Basic load: A5 00 10 00 02, then 78 56 34 12, then EF BE AD DE, then CSUM = XOR of all preceding bytes after SYNC → writes 0x12345678 @0x010 and 0xDEADBEEF @0x011; done pulses once; words_written=2; err=0.
- Wrap-around: ADDR=0x0FFF, CNT=2 → writes land at 0xFFF then 0x000; err=0.
- Timeout: send A5 00 00 00 01 11 22, then silence for TIMEOUT_CYCLES (reduced to 100 in the bench) → err=1, busy=0, ram_wEn never asserted.
- Zero count / garbage: bytes 00 FF then A5 00 20 00 00 CSUM → no writes, done pulses, words_written=0.
- Checksum (macro on): valid frame with CSUM XOR 0x01 → data words still written, err=1, no done. Same frame with macro off → done pulses, err=0.
- Reset mid-DATA after 2 data bytes → no write; outputs back to 0; a following valid frame loads correctly.
